// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Purpose:
//   Decode-side hazard detector. A shadow copy of the EXE, MEM and WB pipeline
//   stages records every in-flight instruction's write information. The block
//   compares the source registers of the instruction in ID against that shadow
//   state and raises `hazard` so decode inserts a bubble until the operand can
//   be read. The shadow pipeline shares the pipeline clock and follows the same
//   freeze and flush events as the real pipeline registers.
//
// Optional feature (macro HAZARD_SCOREBOARD_FORWARDING_EN):
//   Undefined : stall on any RAW dependency against EXE or MEM; fwd_sel_* = 0.
//   Defined   : stall only on load-use against EXE; fwd_sel_a/b pick the EXE
//               operand bypass source (2'b01 = MEM result, 2'b10 = WB result).
//
// Parameters:
//   REG_W  register-address width
//   CNT_W  width of the saturating stall-cycle counter
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous active-low reset
//   src1         in   first source register of the ID instruction
//   src2         in   second source register of the ID instruction
//   two_src      in   src2 is a real operand
//   id_dest      in   destination register of the ID instruction
//   id_wb_en     in   ID instruction writes a register
//   id_mem_r_en  in   ID instruction is a load
//   freeze       in   global pipeline hold
//   flush        in   taken branch; ID contents discarded
//   hazard       out  stall request to IF/ID (combinational)
//   fwd_sel_a    out  EXE operand-A forward select
//   fwd_sel_b    out  EXE operand-B forward select
//   stall_cnt    out  saturating count of non-frozen stall cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             freeze,
  input  logic             flush,
  output logic             hazard,
  output logic [1:0]       fwd_sel_a,
  output logic [1:0]       fwd_sel_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] src1;
    logic [REG_W-1:0] src2;
    logic             two_src;
  } slot_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  slot_t            r_exe;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stall_cnt;

  slot_t            w_id_slot;
  logic             w_hazard;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // A slot only blocks a read if it really holds a register write to r.
  function automatic logic match(input slot_t s, input logic [REG_W-1:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

  assign w_id_slot = '{valid:    1'b1,
                       dest:     id_dest,
                       wb_en:    id_wb_en,
                       mem_r_en: id_mem_r_en,
                       src1:     src1,
                       src2:     src2,
                       two_src:  two_src};

  // hazard looks only at the ID sources and the shadow slots: decode masks its
  // own write enables with hazard, so feeding id_* or flush/freeze back in here
  // would close a combinational loop.
`ifdef HAZARD_SCOREBOARD_FORWARDING_EN
  assign w_hazard = (r_exe.mem_r_en & match(r_exe, src1)) |
                    (two_src & r_exe.mem_r_en & match(r_exe, src2));

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_exe.valid) begin
      // MEM holds the younger result, so it wins over WB.
      if (match(r_mem, r_exe.src1))      w_fwd_a = 2'b01;
      else if (match(r_wb, r_exe.src1))  w_fwd_a = 2'b10;
      if (r_exe.two_src) begin
        if (match(r_mem, r_exe.src2))      w_fwd_b = 2'b01;
        else if (match(r_wb, r_exe.src2))  w_fwd_b = 2'b10;
      end
    end
  end
`else
  // WB is left out: the register file writes through to same-cycle reads.
  assign w_hazard = match(r_exe, src1) | match(r_mem, src1) |
                    (two_src & (match(r_exe, src2) | match(r_mem, src2)));

  assign w_fwd_a = 2'b00;
  assign w_fwd_b = 2'b00;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; the MEM <- EXE <- ID shift relies
  // on it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe       <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_stall_cnt <= '0;
    end else if (!freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_exe;
      // A flushed or stalled ID instruction becomes an all-zero bubble.
      if (flush || w_hazard) r_exe <= '0;
      else                   r_exe <= w_id_slot;
      if (w_hazard && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  // Some slot fields are only consumed in one build; fold them here so the
  // unused bits are explicit rather than silently dangling.
  logic w_unused;
  assign w_unused = ^{r_exe, r_mem, r_wb};

  assign hazard    = w_hazard;
  assign fwd_sel_a = w_fwd_a;
  assign fwd_sel_b = w_fwd_b;
  assign stall_cnt = r_stall_cnt;

endmodule
